bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter_rr_picker.sv | 41 ++++
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the multi-master bus arbiter:
// FSM encoding, default bus widths and arbitration modes.
package bus_arbiter_pkg;

   localparam int ADDR_W_DEF = 27;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } arb_mode_e;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational winner selection: round-robin from last_grant+1,
// or fixed priority with the lowest pending index winning.
module rr_picker
   import bus_arbiter_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] last_grant,
   input  arb_mode_e     mode,
   output logic [IW-1:0] index,
   output logic          valid
);

   logic [IW-1:0] base;
   logic [IW:0]   cand;

   always_comb begin
      base = '0;
      if (mode == MODE_RR && last_grant != IW'(N - 1))
         base = last_grant + IW'(1);
   end

   // Walk offsets from the far end so the nearest hit is written last.
   always_comb begin
      index = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, base} + (IW + 1)'(k);
         if (cand >= (IW + 1)'(N))
            cand = cand - (IW + 1)'(N);
         if (pending[cand[IW-1:0]]) begin
            index = cand[IW-1:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// N-master to single-slave bus arbiter with per-master pending slots,
// a four-state transfer FSM and an optional WAIT timeout.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter  int N_MASTERS = 4,
   parameter  int ADDR_W    = ADDR_W_DEF,
   parameter  int DATA_W    = DATA_W_DEF,
   parameter  int RR_MODE   = 1,
   parameter  int TIMEOUT   = 1023,
   localparam int GW        = idx_w(N_MASTERS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [N_MASTERS*DATA_W-1:0] m_data,
   input  logic [N_MASTERS-1:0]        m_we,
   input  logic [N_MASTERS-1:0]        m_start,
   output logic [N_MASTERS-1:0]        m_done,
   output logic                        m_err,
   output logic [DATA_W-1:0]           m_q,
   output logic [N_MASTERS-1:0]        m_ovf,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic [DATA_W-1:0]           bus_data,
   output logic                        bus_we,
   output logic                        bus_start,
   input  logic [DATA_W-1:0]           bus_q,
   input  logic                        bus_done,
   output logic [GW-1:0]               grant,
   output logic                        busy
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam arb_mode_e MODE = (RR_MODE != 0) ? MODE_RR : MODE_FIXED;
   localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);

   logic [1:0]           state;
   logic [N_MASTERS-1:0] pending;
   logic [ADDR_W-1:0]    slot_addr [N_MASTERS];
   logic [DATA_W-1:0]    slot_data [N_MASTERS];
   logic [N_MASTERS-1:0] slot_we;
   logic [GW-1:0]        last_grant;
   logic [CW-1:0]        cnt;
   logic [GW-1:0]        pick;
   logic                 pick_vld;
   logic [N_MASTERS-1:0] in_flight;
   logic [N_MASTERS-1:0] accept;
   logic [N_MASTERS-1:0] drop;
   logic [N_MASTERS-1:0] clr;
   logic                 timeout_hit;

   rr_picker #(
      .N(N_MASTERS)
   ) u_pick (
      .pending   (pending),
      .last_grant(last_grant),
      .mode      (MODE),
      .index     (pick),
      .valid     (pick_vld)
   );

   assign busy = (state != ST_IDLE);

   // A master is in flight only until its DONE cycle, so a
   // restart coinciding with m_done is taken.
   assign in_flight = (state == ST_ISSUE || state == ST_WAIT)
                    ? (ONE << grant) : '0;
   assign drop   = m_start & (pending | in_flight);
   assign accept = m_start & ~(pending | in_flight);
   assign clr    = (state == ST_IDLE && pick_vld)
                 ? (ONE << pick) : '0;

   assign timeout_hit = (TIMEOUT != 0)
                     && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_MASTERS; i++) begin
         if (accept[i]) begin
            slot_addr[i] <= m_addr[i*ADDR_W +: ADDR_W];
            slot_data[i] <= m_data[i*DATA_W +: DATA_W];
            slot_we[i]   <= m_we[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
         m_ovf   <= '0;
      end else begin
         pending <= (pending & ~clr) | accept;
         m_ovf   <= drop;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= GW'(N_MASTERS - 1);
         cnt        <= '0;
         bus_start  <= 1'b0;
         bus_addr   <= '0;
         bus_data   <= '0;
         bus_we     <= 1'b0;
         m_done     <= '0;
         m_err      <= 1'b0;
         m_q        <= '0;
      end else begin
         bus_start <= 1'b0;
         m_done    <= '0;
         unique case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant     <= pick;
                  bus_addr  <= slot_addr[pick];
                  bus_data  <= slot_data[pick];
                  bus_we    <= slot_we[pick];
                  bus_start <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt <= '0;
               if (bus_done) begin
                  m_q    <= bus_q;
                  m_err  <= 1'b0;
                  m_done <= ONE << grant;
                  state  <= ST_DONE;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus_done) begin
                  m_q    <= bus_q;
                  m_err  <= 1'b0;
                  m_done <= ONE << grant;
                  state  <= ST_DONE;
               end else if (timeout_hit) begin
                  m_err  <= 1'b1;
                  m_done <= ONE << grant;
                  state  <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               last_grant <= grant;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter,
// both with an 8-cycle timeout, driven by directed vectors.
`timescale 1ns/1ps
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int AW = 27;
   localparam int DW = 32;
   localparam int GW = 2;
   localparam int TO = 8;

   typedef struct {
      int inst; int cyc; int idx; logic err; logic [DW-1:0] q;
   } done_t;
   typedef struct {
      int inst; int cyc; int gnt;
      logic [AW-1:0] addr; logic [DW-1:0] data; logic we;
   } req_t;
   typedef struct {
      int inst; int cyc; int idx;
   } ovf_t;

   logic clk = 1'b0;
   logic reset;
   logic [N*AW-1:0] m_addr [2];
   logic [N*DW-1:0] m_data [2];
   logic [N-1:0]    m_we [2];
   logic [N-1:0]    m_start [2];
   logic [N-1:0]    m_done [2];
   logic [N-1:0]    m_ovf [2];
   logic            m_err [2];
   logic [DW-1:0]   m_q [2];
   logic [AW-1:0]   bus_addr [2];
   logic [DW-1:0]   bus_data [2];
   logic [DW-1:0]   bus_q [2];
   logic            bus_we [2];
   logic            bus_start [2];
   logic            bus_done [2];
   logic            busy [2];
   logic [GW-1:0]   grant [2];

   done_t done_exp[$];
   req_t  req_exp[$];
   ovf_t  ovf_exp[$];
   int    n_vec = 0;
   int    n_bad = 0;
   int    cyc = 0;
   int    dly [2][N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bus_arbiter #(
      .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
      .RR_MODE(1), .TIMEOUT(TO)
   ) u_rr (
      .clk(clk), .reset(reset),
      .m_addr(m_addr[0]), .m_data(m_data[0]),
      .m_we(m_we[0]), .m_start(m_start[0]),
      .m_done(m_done[0]), .m_err(m_err[0]),
      .m_q(m_q[0]), .m_ovf(m_ovf[0]),
      .bus_addr(bus_addr[0]), .bus_data(bus_data[0]),
      .bus_we(bus_we[0]), .bus_start(bus_start[0]),
      .bus_q(bus_q[0]), .bus_done(bus_done[0]),
      .grant(grant[0]), .busy(busy[0])
   );

   bus_arbiter #(
      .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
      .RR_MODE(0), .TIMEOUT(TO)
   ) u_fp (
      .clk(clk), .reset(reset),
      .m_addr(m_addr[1]), .m_data(m_data[1]),
      .m_we(m_we[1]), .m_start(m_start[1]),
      .m_done(m_done[1]), .m_err(m_err[1]),
      .m_q(m_q[1]), .m_ovf(m_ovf[1]),
      .bus_addr(bus_addr[1]), .bus_data(bus_data[1]),
      .bus_we(bus_we[1]), .bus_start(bus_start[1]),
      .bus_q(bus_q[1]), .bus_done(bus_done[1]),
      .grant(grant[1]), .busy(busy[1])
   );

   function automatic logic [DW-1:0] slave_q(input logic [AW-1:0] a);
      return 32'h5A00_0000 | {5'd0, a};
   endfunction

   task automatic check(input string name, input bit ok,
                        input string act, input string exp);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %s, want %s", name, act, exp);
      end
   endtask

   task automatic exp_req(input int k, input int cy, input int g,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic we);
      req_t e;
      e.inst = k; e.cyc = cy; e.gnt = g;
      e.addr = a; e.data = d; e.we = we;
      req_exp.push_back(e);
   endtask

   task automatic exp_done(input int k, input int cy, input int i,
                           input logic err, input logic [DW-1:0] q);
      done_t e;
      e.inst = k; e.cyc = cy; e.idx = i; e.err = err; e.q = q;
      done_exp.push_back(e);
   endtask

   task automatic exp_ovf(input int k, input int cy, input int i);
      ovf_t e;
      e.inst = k; e.cyc = cy; e.idx = i;
      ovf_exp.push_back(e);
   endtask

   task automatic req(input int k, input int i, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic we);
      m_start[k][i]          = 1'b1;
      m_addr[k][i*AW +: AW]  = a;
      m_data[k][i*DW +: DW]  = d;
      m_we[k][i]             = we;
   endtask

   task automatic step();
      @(negedge clk);
      m_start[0] = '0;
      m_start[1] = '0;
   endtask

   task automatic tick(input int n);
      repeat (n) step();
   endtask

   task automatic chk_zero(input int k, input string name);
      bit ok;
      ok = m_done[k] == '0 && m_ovf[k] == '0 && !m_err[k]
        && m_q[k] == '0 && bus_addr[k] == '0 && bus_data[k] == '0
        && !bus_we[k] && !bus_start[k] && grant[k] == '0 && !busy[k];
      check(name, ok,
         $sformatf("done=%h ovf=%h err=%b q=%h a=%h d=%h we=%b st=%b g=%0d busy=%b",
            m_done[k], m_ovf[k], m_err[k], m_q[k], bus_addr[k],
            bus_data[k], bus_we[k], bus_start[k], grant[k], busy[k]),
         "all zero");
   endtask

   // slave model: answers dly[k][grant] cycles after bus_start
   initial begin
      int scnt [2];
      scnt[0] = 0;
      scnt[1] = 0;
      bus_done[0] = 1'b0;
      bus_done[1] = 1'b0;
      bus_q[0] = '0;
      bus_q[1] = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            bus_done[k] = 1'b0;
            if (scnt[k] > 0) begin
               scnt[k]--;
               if (scnt[k] == 0) begin
                  bus_done[k] = 1'b1;
                  bus_q[k] = slave_q(bus_addr[k]);
               end
            end
            if (bus_start[k])
               scnt[k] = (dly[k][grant[k]] > 0) ? dly[k][grant[k]] : 0;
         end
      end
   end

   // monitor: pops expectations whenever a DUT output event appears
   initial begin
      req_t  r;
      done_t d;
      ovf_t  o;
      logic [N-1:0]  oh;
      logic [AW-1:0] h_addr [2];
      logic [DW-1:0] h_data [2];
      logic          h_we [2];
      forever begin
         @(negedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (bus_start[k]) begin
               if (req_exp.size() == 0) begin
                  check("bus_req", 1'b0,
                     $sformatf("inst%0d start cyc%0d g=%0d", k, cyc, grant[k]),
                     "no request");
               end else begin
                  r = req_exp.pop_front();
                  check("bus_req",
                     r.inst == k && r.cyc == cyc && grant[k] == GW'(r.gnt)
                     && bus_addr[k] == r.addr && bus_data[k] == r.data
                     && bus_we[k] == r.we,
                     $sformatf("inst%0d cyc%0d g=%0d a=%h d=%h we=%b",
                        k, cyc, grant[k], bus_addr[k], bus_data[k], bus_we[k]),
                     $sformatf("inst%0d cyc%0d g=%0d a=%h d=%h we=%b",
                        r.inst, r.cyc, r.gnt, r.addr, r.data, r.we));
               end
               h_addr[k] = bus_addr[k];
               h_data[k] = bus_data[k];
               h_we[k]   = bus_we[k];
            end else if (busy[k]) begin
               check("bus_hold",
                  bus_addr[k] == h_addr[k] && bus_data[k] == h_data[k]
                  && bus_we[k] == h_we[k],
                  $sformatf("a=%h d=%h we=%b", bus_addr[k], bus_data[k], bus_we[k]),
                  $sformatf("a=%h d=%h we=%b", h_addr[k], h_data[k], h_we[k]));
            end
            if (m_done[k] != '0) begin
               if (done_exp.size() == 0) begin
                  check("m_done", 1'b0,
                     $sformatf("inst%0d cyc%0d done=%b", k, cyc, m_done[k]),
                     "no completion");
               end else begin
                  d = done_exp.pop_front();
                  oh = '0;
                  oh[d.idx] = 1'b1;
                  check("m_done",
                     d.inst == k && d.cyc == cyc && m_done[k] == oh
                     && m_err[k] == d.err && m_q[k] == d.q,
                     $sformatf("inst%0d cyc%0d done=%b err=%b q=%h",
                        k, cyc, m_done[k], m_err[k], m_q[k]),
                     $sformatf("inst%0d cyc%0d done=%b err=%b q=%h",
                        d.inst, d.cyc, oh, d.err, d.q));
               end
            end
            if (m_ovf[k] != '0) begin
               if (ovf_exp.size() == 0) begin
                  check("m_ovf", 1'b0,
                     $sformatf("inst%0d cyc%0d ovf=%b", k, cyc, m_ovf[k]),
                     "no overflow");
               end else begin
                  o = ovf_exp.pop_front();
                  oh = '0;
                  oh[o.idx] = 1'b1;
                  check("m_ovf",
                     o.inst == k && o.cyc == cyc && m_ovf[k] == oh,
                     $sformatf("inst%0d cyc%0d ovf=%b", k, cyc, m_ovf[k]),
                     $sformatf("inst%0d cyc%0d ovf=%b", o.inst, o.cyc, oh));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200us");
      $fatal(1);
   end

   initial begin
      int c;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_addr[k] = '0; m_data[k] = '0;
         m_we[k] = '0; m_start[k] = '0;
         for (int i = 0; i < N; i++) dly[k][i] = 1;
      end
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero(0, "reset_rr");
      chk_zero(1, "reset_fp");
      @(negedge clk);
      reset = 1'b1;
      tick(2);

      // round-robin burst, twice
      for (int b = 0; b < 2; b++) begin
         c = cyc;
         for (int i = 0; i < N; i++) begin
            req(0, i, AW'(32'h100 * (b + 1) + i), 32'h1000_0000 + i, (i % 2) == 1);
            exp_req(0, c + 2 + 4 * i, i, AW'(32'h100 * (b + 1) + i),
                    32'h1000_0000 + i, (i % 2) == 1);
            exp_done(0, c + 4 + 4 * i, i, 1'b0,
                     slave_q(AW'(32'h100 * (b + 1) + i)));
         end
         tick(20);
      end

      // single write from master 2, three-cycle slave
      dly[0][2] = 3;
      c = cyc;
      req(0, 2, 27'h0000123, 32'hDEADBEEF, 1'b1);
      exp_req(0, c + 2, 2, 27'h0000123, 32'hDEADBEEF, 1'b1);
      exp_done(0, c + 6, 2, 1'b0, 32'h5A00_0123);
      tick(10);

      // duplicate while pending, restart on m_done, duplicate in flight
      dly[0][1] = 2;
      c = cyc;
      req(0, 1, 27'h00000AA, 32'h0000_00AA, 1'b0);
      step();
      req(0, 1, 27'h00000BB, 32'h0000_00BB, 1'b1);
      exp_ovf(0, c + 2, 1);
      exp_req(0, c + 2, 1, 27'h00000AA, 32'h0000_00AA, 1'b0);
      exp_done(0, c + 5, 1, 1'b0, slave_q(27'h00000AA));
      tick(4);
      req(0, 1, 27'h00000CC, 32'h0000_00CC, 1'b1);
      exp_req(0, c + 7, 1, 27'h00000CC, 32'h0000_00CC, 1'b1);
      exp_done(0, c + 10, 1, 1'b0, slave_q(27'h00000CC));
      tick(3);
      req(0, 1, 27'h00000DD, 32'h0000_00DD, 1'b0);
      exp_ovf(0, c + 9, 1);
      tick(6);

      // timeout on master 3, then master 0 served
      dly[0][3] = -1;
      dly[0][0] = 1;
      c = cyc;
      req(0, 0, 27'h0000300, 32'h0000_0003, 1'b1);
      req(0, 3, 27'h0000333, 32'h0000_0033, 1'b0);
      exp_req(0, c + 2, 3, 27'h0000333, 32'h0000_0033, 1'b0);
      exp_done(0, c + 11, 3, 1'b1, slave_q(27'h00000CC));
      exp_req(0, c + 13, 0, 27'h0000300, 32'h0000_0003, 1'b1);
      exp_done(0, c + 15, 0, 1'b0, slave_q(27'h0000300));
      tick(18);

      // fixed priority: 3 and 1 pending, 0 arrives mid-transfer
      dly[1][0] = 1;
      dly[1][1] = 3;
      dly[1][3] = 1;
      c = cyc;
      req(1, 3, 27'h00003C3, 32'h0000_03C3, 1'b1);
      req(1, 1, 27'h00001C1, 32'h0000_01C1, 1'b0);
      exp_req(1, c + 2, 1, 27'h00001C1, 32'h0000_01C1, 1'b0);
      exp_done(1, c + 6, 1, 1'b0, slave_q(27'h00001C1));
      exp_req(1, c + 8, 0, 27'h00000C0, 32'h0000_00C0, 1'b1);
      exp_done(1, c + 10, 0, 1'b0, slave_q(27'h00000C0));
      exp_req(1, c + 12, 3, 27'h00003C3, 32'h0000_03C3, 1'b1);
      exp_done(1, c + 14, 3, 1'b0, slave_q(27'h00003C3));
      tick(3);
      req(1, 0, 27'h00000C0, 32'h0000_00C0, 1'b1);
      tick(15);

      // reset during WAIT, slave answers afterwards
      dly[0][2] = 5;
      c = cyc;
      req(0, 2, 27'h0000222, 32'h0000_0022, 1'b1);
      exp_req(0, c + 2, 2, 27'h0000222, 32'h0000_0022, 1'b1);
      tick(4);
      reset = 1'b0;
      #1;
      chk_zero(0, "reset_in_wait");
      step();
      reset = 1'b1;
      tick(6);
      #1;
      chk_zero(0, "after_late_done");

      // last_grant restored: master 0 beats master 1
      dly[0][0] = 1;
      dly[0][1] = 1;
      @(negedge clk);
      c = cyc;
      req(0, 0, 27'h0000010, 32'h0000_0010, 1'b0);
      req(0, 1, 27'h0000011, 32'h0000_0011, 1'b1);
      exp_req(0, c + 2, 0, 27'h0000010, 32'h0000_0010, 1'b0);
      exp_done(0, c + 4, 0, 1'b0, slave_q(27'h0000010));
      exp_req(0, c + 6, 1, 27'h0000011, 32'h0000_0011, 1'b1);
      exp_done(0, c + 8, 1, 1'b0, slave_q(27'h0000011));
      tick(12);

      check("sb_drain",
         req_exp.size() == 0 && done_exp.size() == 0 && ovf_exp.size() == 0,
         $sformatf("left req=%0d done=%0d ovf=%0d",
            req_exp.size(), done_exp.size(), ovf_exp.size()),
         "left 0/0/0");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
